// File: rtl/load_store_unit.sv
// Load/store unit: one core memory access at a time, with byte-lane steering,
// load extension, alignment checking and an ack timeout.
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_next;

    logic          accept, legal, misaligned, f3_ok;
    logic [3:0]    be_c;
    logic [31:0]   wd_c;
    logic [2:0]    f3_q;
    logic [1:0]    lo_q;
    logic          load_q, err_q;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ext;

    assign accept  = start && (is_load ^ is_store);
    assign busy    = (state != IDLE);
    assign done    = (state == RESP);
    assign err     = done && err_q;
    assign mem_req = (state == ACCESS);

    always_comb begin
        f3_ok      = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            3'd0: f3_ok = 1'b1;
            3'd1: begin f3_ok = 1'b1; misaligned = addr[0]; end
            3'd2: begin f3_ok = 1'b1; misaligned = (addr[1:0] != 2'b00); end
            3'd4: f3_ok = is_load;
            3'd5: begin f3_ok = is_load; misaligned = addr[0]; end
            default: f3_ok = 1'b0;
        endcase
        legal = f3_ok && !misaligned;
    end

    // Store data is replicated across lanes so the memory only needs mem_be.
    always_comb begin
        be_c = 4'b1111;
        wd_c = '0;
        if (!is_load) begin
            case (funct3[1:0])
                2'd0: begin be_c = 4'b0001 << addr[1:0]; wd_c = {4{wdata[7:0]}}; end
                2'd1: begin be_c = addr[1] ? 4'b1100 : 4'b0011; wd_c = {2{wdata[15:0]}}; end
                default: begin be_c = 4'b1111; wd_c = wdata; end
            endcase
        end
    end

    always_comb begin
        case (lo_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'd0:    ext = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    ext = {{16{half_sel[15]}}, half_sel};
            3'd4:    ext = {24'd0, byte_sel};
            3'd5:    ext = {16'd0, half_sel};
            default: ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = legal ? ACCESS : RESP;
            ACCESS:  if (mem_ack || tmo_cnt == TMO_LAST) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            f3_q      <= '0;
            lo_q      <= '0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_cnt   <= '0;
            rdata     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (accept) begin
                        f3_q   <= funct3;
                        lo_q   <= addr[1:0];
                        load_q <= is_load;
                        err_q  <= !legal;
                        if (legal) begin
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wd_c;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (load_q) rdata <= ext;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level reference model
// checked every cycle, plus hand-computed expectations for key scenarios.
module tb_load_store_unit;
    localparam int unsigned T = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int nchecks = 0;
    int nerrors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_req(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        if (ld) begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        end else if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        if (ld) return 4'hF;
        case (f3)
            3'd0:    return 4'(1 << (a % 4));
            3'd1:    return 4'(3 << (a & 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input bit ld, input logic [2:0] f3, input logic [31:0] wd);
        if (ld) return 32'd0;
        case (f3)
            3'd0:    return (wd & 32'hFF) * 32'h01010101;
            3'd1:    return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int unsigned sh;
        sh = 8 * (a % 4);
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> sh) & 32'hFF;
                if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFFFF00;
            end
            3'd1, 3'd5: begin
                v = (w >> sh) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    bit          m_active, m_resp, m_err, m_load;
    logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
    logic [2:0]  m_f3 = '0;
    int          m_wait;

    always @(posedge clk) begin
        if (!rst) begin
            m_active = 0; m_resp = 0; m_err = 0; m_rdata = '0; m_wait = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_active) begin
            if (mem_ack) begin
                m_active = 0; m_resp = 1; m_err = 0;
                if (m_load) m_rdata = extract(m_f3, m_addr, mem_rdata);
            end else begin
                m_wait++;
                if (m_wait == T) begin m_active = 0; m_resp = 1; m_err = 1; end
            end
        end else if (start && (is_load != is_store)) begin
            m_load = is_load; m_f3 = funct3; m_addr = addr; m_wdata = wdata;
            if (legal_req(is_load, funct3, addr)) begin m_active = 1; m_wait = 0; end
            else begin m_resp = 1; m_err = 1; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_active || m_resp);
            chk("done", done, m_resp);
            chk("err", err, m_resp && m_err);
            chk("rdata", rdata, m_rdata);
            chk("mem_req", mem_req, m_active);
            if (m_active) begin
                chk("mem_addr", mem_addr, m_addr & ~32'h3);
                chk("mem_we", mem_we, !m_load);
                chk("mem_be", mem_be, exp_be(m_load, m_f3, m_addr));
                chk("mem_wdata", mem_wdata, exp_wd(m_load, m_f3, m_wdata));
            end
        end
    end

    // ack_at <= 0 means the memory never acknowledges.
    task automatic run(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int ack_at, input logic [31:0] word,
                       input bit hold_start, output int dc, output logic [31:0] cap_addr,
                       output logic [3:0] cap_be, output logic [31:0] cap_wd, output logic cap_req,
                       output logic cap_we, output logic d_err, output logic [31:0] d_rdata);
        @(posedge clk); #1;
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
        dc = -1; cap_addr = '0; cap_be = '0; cap_wd = '0; cap_req = 1'b0; cap_we = 1'b0;
        d_err = 1'b0; d_rdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = hold_start;
            if (hold_start) addr = a ^ 32'h40;
            mem_ack = (ack_at > 0 && c >= ack_at);
            mem_rdata = mem_ack ? word : 32'hA5A55A5A;
            @(negedge clk);
            if (c == 1) begin
                cap_addr = mem_addr; cap_be = mem_be; cap_wd = mem_wdata;
                cap_req = mem_req; cap_we = mem_we;
            end
            if (done) begin dc = c; d_err = err; d_rdata = rdata; break; end
        end
        start = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        logic [31:0] ca, cw, dr;
        logic [3:0] cb;
        logic cr, cwe, de;
        bit seen;

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0); chk("rst_mem_req", mem_req, 0); chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0); chk("rst_mem_be", mem_be, 0);
        rst = 1'b1;

        run(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 3, 32'h0, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("sw_done_cycle", dc, 4); chk("sw_addr", ca, 32'h100); chk("sw_be", cb, 4'hF);
        chk("sw_we", cwe, 1); chk("sw_wdata", cw, 32'hDEADBEEF); chk("sw_err", de, 0);

        run(1, 0, 3'd0, 32'h103, 32'h0, 1, 32'h80FFFF7F, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("lb_done_cycle", dc, 2); chk("lb_rdata", dr, 32'hFFFFFF80);
        run(1, 0, 3'd4, 32'h103, 32'h0, 1, 32'h80FFFF7F, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("lbu_rdata", dr, 32'h00000080);

        run(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 2, 32'h0, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("sh_be", cb, 4'hC); chk("sh_wdata", cw, 32'hABCDABCD); chk("sh_done_cycle", dc, 3);
        run(1, 0, 3'd5, 32'h102, 32'h0, 1, 32'hBEEF0000, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("lhu_rdata", dr, 32'h0000BEEF);

        run(1, 0, 3'd2, 32'h101, 32'h0, 1, 32'h0, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("lw_mis_req", cr, 0); chk("lw_mis_done_cycle", dc, 1); chk("lw_mis_err", de, 1);
        chk("lw_mis_rdata_kept", dr, 32'h0000BEEF);

        run(1, 0, 3'd2, 32'h104, 32'h0, 0, 32'h0, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("tmo_done_cycle", dc, T + 1); chk("tmo_err", de, 1); chk("tmo_rdata_kept", dr, 32'h0000BEEF);
        @(negedge clk);
        chk("tmo_req_after", mem_req, 0);

        run(0, 1, 3'd0, 32'h101, 32'hCAFE0077, 1, 32'h0, 1, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("sb_be", cb, 4'h2); chk("sb_wdata", cw, 32'h77777777); chk("sb_done_cycle", dc, 2);
        run(1, 0, 3'd1, 32'h100, 32'h0, 2, 32'h12348001, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("lh_rdata", dr, 32'hFFFF8001);
        run(1, 0, 3'd1, 32'h106, 32'h0, 1, 32'h7FFF0000, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("lh_hi_rdata", dr, 32'h00007FFF);
        run(1, 0, 3'd2, 32'h108, 32'h0, 1, 32'h13579BDF, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("lw_rdata", dr, 32'h13579BDF);

        run(1, 0, 3'd3, 32'h100, 32'h0, 1, 32'h0, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("bad_f3_load_cycle", dc, 1); chk("bad_f3_load_err", de, 1);
        run(0, 1, 3'd4, 32'h100, 32'h0, 1, 32'h0, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("bad_f3_store_cycle", dc, 1); chk("bad_f3_store_err", de, 1);
        run(1, 1, 3'd2, 32'h100, 32'h0, 1, 32'h0, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("both_ignored", dc, -1);

        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        repeat (3) @(negedge clk);
        chk("idle_ack_ignored", busy, 0);
        mem_ack = 1'b0;

        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h200;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        chk("mid_rst_req", mem_req, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_rdata", rdata, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done;
        end
        chk("mid_rst_no_done", seen, 0);
        mem_ack = 1'b0;

        run(1, 0, 3'd2, 32'h200, 32'h0, 2, 32'h0F0F0F0F, 0, dc, ca, cb, cw, cr, cwe, de, dr);
        chk("post_rst_cycle", dc, 3); chk("post_rst_rdata", dr, 32'h0F0F0F0F); chk("post_rst_err", de, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles in ACCESS waiting for mem_ack before aborting.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  core request strobe, sampled only in IDLE.
REQ-005 is_load / is_store  in  1 each  access type from decoder.
REQ-006 funct3  in  3  size/sign: 0=B, 1=H, 2=W, 4=BU, 5=HU (loads); 0=B, 1=H, 2=W (stores).
REQ-007 addr  in  32  byte address (ALU result); wdata  in  32  store data (rs2 value).
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 done  out  1  one-cycle completion pulse; err  out  1  valid with done, 1 = access failed.
REQ-010 rdata  out  32  extended load result, valid from done and held until next load's done.
REQ-011 mem_req, mem_we  out  1 each; mem_addr  out  32; mem_wdata  out  32; mem_be  out  4.
REQ-012 mem_ack  in  1; mem_rdata  in  32 (word at mem_addr, valid with mem_ack).

Function
REQ-013 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-014 IDLE: start=1 with exactly one of is_load/is_store latches addr, wdata, funct3, type; start with both or neither set is ignored.
REQ-015 Legality check in IDLE: misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) or unlisted funct3 -> go RESP with err=1, no memory request issued.
REQ-016 Legal request -> ACCESS next edge; mem_req=1 from first ACCESS cycle.
REQ-017 ACCESS: mem_req, mem_we, mem_addr, mem_be, mem_wdata stable until ack or timeout.
REQ-018 mem_addr = {addr[31:2], 2'b00}; mem_we=1 for stores only.
REQ-019 Stores: B -> mem_be = 4'b0001 << addr[1:0], byte replicated in all 4 lanes; H -> mem_be = 4'b0011 << (2*addr[1]), halfword replicated twice; W -> 4'b1111, wdata as-is.
REQ-020 Loads: mem_be = 4'b1111; mem_wdata = 0.
REQ-021 mem_ack high in ACCESS (including first ACCESS cycle) -> RESP next edge; mem_req low from that edge.
REQ-022 Load extraction registered on ack: B/BU select byte at addr[1:0], H/HU select half at addr[1]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-023 ACK_TIMEOUT consecutive ACCESS cycles without ack -> RESP with err=1; rdata unchanged.
REQ-024 RESP lasts exactly one cycle: done=1, busy=1; then IDLE.
REQ-025 Latency: start at cycle 0, ack at cycle k>=1 -> done at cycle k+1; illegal request -> done at cycle 1.
REQ-026 Stores and errored accesses leave rdata unchanged.
REQ-027 start while busy ignored (no queueing); mem_ack outside ACCESS ignored.
REQ-028 Back-to-back: start may be accepted in the IDLE cycle immediately after RESP.

Reset
REQ-029 rst=0 at an edge -> state IDLE, busy=0, done=0, err=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, timeout counter=0.
REQ-030 Reset mid-ACCESS aborts transaction; no done pulse; pending ack after reset ignored.

Verification
REQ-031 SW addr=0x100, wdata=0xDEADBEEF, ack at cycle 3 -> mem_addr=0x100, be=1111, we=1, done at cycle 4, err=0.
REQ-032 LB addr=0x103, mem_rdata=0x80FF_FF7F -> rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr=0x102, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD; LHU addr=0x102 rdata word 0xBEEF0000 -> 0x0000BEEF.
REQ-034 LW addr=0x101 -> no mem_req, done+err at cycle 1.
REQ-035 LW with mem_ack never asserted -> done+err exactly ACK_TIMEOUT+1 cycles after start, mem_req low afterwards.
REQ-036 rst=0 during ACCESS, then ack -> no done; mem_req=0 after reset edge; new LW afterwards completes normally.
